app_loader_v2: RTL
==================

Name: app_loader_v2

Overview:
- Parametrised successor to the radio-processor app loader.
- Peripheral on the radio openMSP430 bus that holds the application processor in reset and streams firmware into its pmem.
- Adds: programmable start address, byte-lane writes, pmem read-back for verify, running 16-bit write checksum, and busy/overflow/error status.
- All pmem accesses are single-edge (posedge mclk) through a small FSM.

Parameters:
- BASE_ADDR, 15'h00A8, peripheral base address (aligned to 2^DEC_WD).
- DEC_WD, 3, decoder width; gives four word registers.
- AW, 13, app pmem word-address width.

Ports:
- mclk  in  1  main clock
- puc_rst  in  1  reset
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables
- app_pmem_din  in  16  app pmem read data, valid the cycle after a read strobe
- per_dout  out  16  peripheral read data
- app_reset_n  out  1  app processor reset, active-low
- app_pmem_addr  out  AW  app pmem address
- app_pmem_dout  out  16  app pmem write data
- app_pmem_cen  out  1  chip enable, active-low
- app_pmem_wen  out  2  byte write enables, active-low

Behaviour:
- Interface: reset puc_rst, asynchronous, active-high; clock mclk. All flops are on posedge mclk.
- Reset values: app_reset_n=1, app_pmem_cen=1, app_pmem_wen=2'b11, app_pmem_addr=0, app_pmem_dout=0, per_dout=0. All registers are 0 and the FSM is in IDLE.
- Registers (byte offset):
  - CTRL 0x0:
    - [0] EN, R/W.
    - [1] RD_GO, write-1 pulse, reads 0.
    - [8] BUSY, read-only.
    - [9] OVF, sticky, write-1-to-clear.
    - [10] ERR, sticky, write-1-to-clear.
    - Other bits read 0.
  - ADDR 0x2: current pmem address, zero-extended to 16 bits.
  - DATA 0x4: write = pmem write data; read = last read-back word.
  - CSUM 0x6: read-only; writes are ignored.
- per_dout is combinational, gated by read select; 0 when not selected.
- EN rising (0->1): same cycle ADDR:=0, CSUM:=0, OVF:=0, ERR:=0. app_reset_n goes low on the next edge.
- app_reset_n is registered. It equals ~(EN | FSM!=IDLE). EN falling therefore lets an in-flight access finish before the app is released.
- ADDR write:
  - Accepted only when EN=1 and FSM=IDLE; loads per_din[AW-1:0].
  - Otherwise it is dropped, and ERR is set if EN=1.
- FSM states:
  - IDLE
  - WR: 1 cycle
  - RD_ACC: 1 cycle
  - RD_CAP: 1 cycle
- DATA write accepted (EN=1, IDLE), write cycle N:
  - Latch dout=per_din and be=per_we.
  - In cycle N+1 (WR): cen=0, wen=~be, addr stable.
  - At the end of WR: address+=1, CSUM += (per_din masked to enabled bytes) mod 2^16, then IDLE.
- RD_GO written (EN=1, IDLE), cycle N:
  - N+1 RD_ACC: cen=0, wen=11.
  - N+2 RD_CAP: rdata:=app_pmem_din, address+=1.
  - Then IDLE. CSUM is unchanged.
- BUSY = (FSM != IDLE).
- DATA write or RD_GO while BUSY: dropped, ERR set.
- DATA write or RD_GO with EN=0: silently ignored, no ERR.
- Address wrap: an access completing at address 2^AW-1 wraps to 0 and sets OVF.
- A CTRL write sets EN from per_din[0]. The W1C bits clear in the same write. RD_GO in the same write as the EN 0->1 transition is ignored.
- Reset mid-access: everything returns to reset values immediately. cen/wen deassert asynchronously.

Test Plan:
- Reset -> app_reset_n=1, cen=1, wen=11; CTRL/ADDR/DATA/CSUM read 0.
- CTRL=0x1; ADDR=0x0100; DATA=0x1234; DATA=0xABCD -> two cen=0/wen=00 pulses at addr 0x100 and 0x101, dout matching each. ADDR reads 0x0102, CSUM=0xBE01, app_reset_n=0 throughout.
- DATA=0xFFFF with per_we=01 at ADDR=0x10 -> wen=10, CSUM increments by 0x00FF. RD_GO at ADDR=0x10 with model returning 0x55AA -> RD_ACC cen=0/wen=11, DATA reads 0x55AA, ADDR=0x11.
- ADDR=0x1FFF (AW=13), DATA write -> ADDR reads 0, CTRL[9]=1. Write CTRL=0x201 -> OVF clears, EN stays 1.
- DATA write then a second DATA write on the very next cycle (BUSY) -> only one pmem strobe, CTRL[10]=1. DATA write with EN=0 -> no strobe, ERR unchanged.
- CTRL=0x0 written in the cycle BUSY is asserted -> WR completes, app_reset_n returns to 1 one cycle after IDLE. Assert puc_rst during RD_ACC -> cen=1 immediately, all registers 0.

Source files
------------

// File: rtl/app_loader_v2.sv
// Firmware loader on the radio openMSP430 peripheral bus: holds the application core
// in reset and streams words into (or reads back from) its program memory.
module app_loader_v2 #(
  parameter logic [14:0] BASE_ADDR = 15'h00A8,
  parameter int unsigned DEC_WD    = 3,
  parameter int unsigned AW        = 13
) (
  input  logic          mclk,
  input  logic          puc_rst,
  input  logic [13:0]   per_addr,
  input  logic [15:0]   per_din,
  input  logic          per_en,
  input  logic [1:0]    per_we,
  input  logic [15:0]   app_pmem_din,
  output logic [15:0]   per_dout,
  output logic          app_reset_n,
  output logic [AW-1:0] app_pmem_addr,
  output logic [15:0]   app_pmem_dout,
  output logic          app_pmem_cen,
  output logic [1:0]    app_pmem_wen
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR     = 2'd1;
  localparam logic [1:0] S_RD_ACC = 2'd2;
  localparam logic [1:0] S_RD_CAP = 2'd3;

  localparam logic [DEC_WD-2:0] IDX_CTRL = (DEC_WD-1)'(0);
  localparam logic [DEC_WD-2:0] IDX_ADDR = (DEC_WD-1)'(1);
  localparam logic [DEC_WD-2:0] IDX_DATA = (DEC_WD-1)'(2);
  localparam logic [DEC_WD-2:0] IDX_CSUM = (DEC_WD-1)'(3);

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   dout_q, dout_d;
  logic [1:0]    be_q, be_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   csum_q, csum_d;
  logic          rst_n_q, rst_n_d;

  logic              reg_sel, reg_wr, reg_rd, busy;
  logic [DEC_WD-2:0] idx;
  logic              ctrl_wr, addr_wr, data_wr;
  logic              en_rise, data_req, rd_req, addr_req;
  logic [15:0]       masked;

  assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_wr  = reg_sel & (|per_we);
  assign reg_rd  = reg_sel & ~(|per_we);
  assign idx     = per_addr[DEC_WD-2:0];
  assign busy    = (state_q != S_IDLE);

  assign ctrl_wr = reg_wr & (idx == IDX_CTRL);
  assign addr_wr = reg_wr & (idx == IDX_ADDR);
  assign data_wr = reg_wr & (idx == IDX_DATA);

  assign en_rise  = ctrl_wr & per_din[0] & ~en_q;
  assign data_req = data_wr & en_q;
  assign rd_req   = ctrl_wr & per_din[1] & en_q;
  assign addr_req = addr_wr & en_q;

  assign masked = {be_q[1] ? dout_q[15:8] : 8'h00, be_q[0] ? dout_q[7:0] : 8'h00};

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    csum_d  = csum_q;
    rst_n_d = ~(en_q | busy);

    if (ctrl_wr) begin
      en_d = per_din[0];
      if (per_din[9])  ovf_d = 1'b0;
      if (per_din[10]) err_d = 1'b0;
    end

    if ((data_req | rd_req | addr_req) & busy) err_d = 1'b1;

    if (!busy) begin
      if (addr_req) addr_d = per_din[AW-1:0];
      if (data_req) begin
        dout_d  = per_din;
        be_d    = per_we;
        state_d = S_WR;
      end else if (rd_req) begin
        state_d = S_RD_ACC;
      end
    end

    case (state_q)
      S_WR: begin
        addr_d  = addr_q + AW'(1);
        csum_d  = csum_q + masked;
        if (addr_q == '1) ovf_d = 1'b1;
        state_d = S_IDLE;
      end
      S_RD_ACC: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rdata_d = app_pmem_din;
        addr_d  = addr_q + AW'(1);
        if (addr_q == '1) ovf_d = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // A fresh enable restarts the session even if a previous access is still retiring.
    if (en_rise) begin
      addr_d = '0;
      csum_d = '0;
      ovf_d  = 1'b0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      csum_q  <= '0;
      rst_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      csum_q  <= csum_d;
      rst_n_q <= rst_n_d;
    end
  end

  // Strobes decode straight from the state flops so reset drops them asynchronously.
  assign app_pmem_cen  = ~((state_q == S_WR) | (state_q == S_RD_ACC));
  assign app_pmem_wen  = (state_q == S_WR) ? ~be_q : 2'b11;
  assign app_pmem_addr = addr_q;
  assign app_pmem_dout = dout_q;
  assign app_reset_n   = rst_n_q;

  always_comb begin
    per_dout = '0;
    if (reg_rd) begin
      case (idx)
        IDX_CTRL: per_dout = {5'b0, err_q, ovf_q, busy, 7'b0, en_q};
        IDX_ADDR: per_dout = 16'(addr_q);
        IDX_DATA: per_dout = rdata_q;
        IDX_CSUM: per_dout = csum_q;
        default:  per_dout = '0;
      endcase
    end
  end

endmodule
